// File: rtl/ahb_filter_pkg.sv
// Shared types and AHB-Lite constants for the address filter / default slave.
package ahb_filter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ERR1 = 2'b01,
        ST_ERR2 = 2'b10
    } fsm_state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Only NONSEQ/SEQ carry a real transfer; IDLE/BUSY always get a zero-wait OKAY.
    function automatic logic isActiveTrans(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_region_decode.sv
// Combinational region compare and priority encoder: the lowest matching index wins.
module ahb_region_decode #(
    parameter int NB_SLAVES  = 6,
    parameter int ADDR_WIDTH = 32,
    parameter int IDX_WIDTH  = 3,
    parameter logic [NB_SLAVES-1:0][ADDR_WIDTH-1:0] REGION_BASE = '0,
    parameter logic [NB_SLAVES-1:0][ADDR_WIDTH-1:0] REGION_END  = '0
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [NB_SLAVES-1:0]  en_i,
    output logic [NB_SLAVES-1:0]  onehot_o,
    output logic [IDX_WIDTH-1:0]  idx_o,
    output logic                  hit_o
);

    logic [ADDR_WIDTH:0] lowDiff;
    logic [ADDR_WIDTH:0] highDiff;

    // Bounds are tested through the borrow of a widened subtraction, so an
    // inverted region (base > end) simply never satisfies both sides.
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        hit_o    = 1'b0;
        lowDiff  = '0;
        highDiff = '0;
        for (int i = NB_SLAVES - 1; i >= 0; i--) begin
            lowDiff  = {1'b0, addr_i} - {1'b0, REGION_BASE[i]};
            highDiff = {1'b0, REGION_END[i]} - {1'b0, addr_i};
            if (en_i[i] && !lowDiff[ADDR_WIDTH] && !highDiff[ADDR_WIDTH]) begin
                onehot_o    = '0;
                onehot_o[i] = 1'b1;
                idx_o       = IDX_WIDTH'(i);
                hit_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_addr_filter_err.sv
// AHB-Lite address decoder with built-in default slave that answers unmapped or
// disabled accesses with a two-cycle ERROR, plus first-error capture and a count.
module ahb_addr_filter_err
    import ahb_filter_pkg::*;
#(
    parameter int NB_SLAVES  = 6,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 8,
    parameter logic [NB_SLAVES-1:0][ADDR_WIDTH-1:0] REGION_BASE = {
        32'h5000_0000, 32'h4000_0000, 32'h3000_0000,
        32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [NB_SLAVES-1:0][ADDR_WIDTH-1:0] REGION_END = {
        32'h5FFF_FFFF, 32'h4FFF_FFFF, 32'h3FFF_FFFF,
        32'h2FFF_FFFF, 32'h1FFF_FFFF, 32'h0FFF_FFFF}
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [ADDR_WIDTH-1:0]        haddr_i,
    input  logic [1:0]                   htrans_i,
    input  logic                         hwrite_i,
    input  logic                         hsel_i,
    input  logic                         hready_i,
    input  logic [NB_SLAVES-1:0]         slv_en_i,
    output logic [NB_SLAVES-1:0]         hsel_slv_o,
    output logic [$clog2(NB_SLAVES)-1:0] dsel_o,
    output logic                         dsel_def_o,
    output logic                         def_hreadyout_o,
    output logic                         def_hresp_o,
    output logic                         err_valid_o,
    output logic [ADDR_WIDTH-1:0]        err_addr_o,
    output logic                         err_write_o,
    output logic [CNT_WIDTH-1:0]         err_cnt_o,
    input  logic                         err_clr_i
);

    localparam int IDX_WIDTH = $clog2(NB_SLAVES);

    logic [NB_SLAVES-1:0] winOneHot;
    logic [IDX_WIDTH-1:0] winIdx;
    logic                 winHit;

    logic accepted;
    logic unmappedReq;
    logic errEvent;

    fsm_state_e           state_q;
    logic                 hreadyout_q;
    logic                 hresp_q;
    logic [IDX_WIDTH-1:0] dsel_q;
    logic                 dselDef_q;

    logic                  errValid_q, errValid_d;
    logic [ADDR_WIDTH-1:0] errAddr_q,  errAddr_d;
    logic                  errWrite_q, errWrite_d;
    logic [CNT_WIDTH-1:0]  errCnt_q,   errCnt_d;

    ahb_region_decode #(
        .NB_SLAVES  (NB_SLAVES),
        .ADDR_WIDTH (ADDR_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH),
        .REGION_BASE(REGION_BASE),
        .REGION_END (REGION_END)
    ) u_decode (
        .addr_i  (haddr_i),
        .en_i    (slv_en_i),
        .onehot_o(winOneHot),
        .idx_o   (winIdx),
        .hit_o   (winHit)
    );

    assign hsel_slv_o  = hsel_i ? winOneHot : '0;
    assign accepted    = hsel_i && hready_i;
    assign unmappedReq = accepted && isActiveTrans(htrans_i) && !winHit;
    // ERR1 stalls the bus itself, so a new error can only start from IDLE or ERR2.
    assign errEvent    = unmappedReq && (state_q != ST_ERR1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dsel_q    <= '0;
            dselDef_q <= 1'b1;
        end else if (hready_i) begin
            if (hsel_i) begin
                dsel_q    <= winIdx;
                dselDef_q <= !winHit;
            end else begin
                dselDef_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (unmappedReq) begin
                        state_q     <= ST_ERR1;
                        hreadyout_q <= 1'b0;
                        hresp_q     <= HRESP_ERROR;
                    end
                end
                ST_ERR1: begin
                    state_q     <= ST_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_ERROR;
                end
                ST_ERR2: begin
                    if (unmappedReq) begin
                        state_q     <= ST_ERR1;
                        hreadyout_q <= 1'b0;
                        hresp_q     <= HRESP_ERROR;
                    end else begin
                        state_q     <= ST_IDLE;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= HRESP_OKAY;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_OKAY;
                end
            endcase
        end
    end

    // A clear coinciding with a new error restarts the capture with that error.
    always_comb begin
        errValid_d = errValid_q;
        errAddr_d  = errAddr_q;
        errWrite_d = errWrite_q;
        errCnt_d   = errCnt_q;
        if (err_clr_i) begin
            errValid_d = 1'b0;
            errCnt_d   = '0;
        end
        if (errEvent) begin
            if (!errValid_q || err_clr_i) begin
                errValid_d = 1'b1;
                errAddr_d  = haddr_i;
                errWrite_d = hwrite_i;
            end
            if (err_clr_i) begin
                errCnt_d = CNT_WIDTH'(1);
            end else if (errCnt_q != '1) begin
                errCnt_d = errCnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            errValid_q <= 1'b0;
            errAddr_q  <= '0;
            errWrite_q <= 1'b0;
            errCnt_q   <= '0;
        end else begin
            errValid_q <= errValid_d;
            errAddr_q  <= errAddr_d;
            errWrite_q <= errWrite_d;
            errCnt_q   <= errCnt_d;
        end
    end

    assign dsel_o          = dsel_q;
    assign dsel_def_o      = dselDef_q;
    assign def_hreadyout_o = hreadyout_q;
    assign def_hresp_o     = hresp_q;
    assign err_valid_o     = errValid_q;
    assign err_addr_o      = errAddr_q;
    assign err_write_o     = errWrite_q;
    assign err_cnt_o       = errCnt_q;

endmodule

// File: tb/tb_ahb_addr_filter_err.sv
// Scoreboard bench: each driven cycle queues the expected post-edge outputs,
// and an independent monitor pops and compares one entry per clock.
module tb_ahb_addr_filter_err;
    import ahb_filter_pkg::*;

    typedef struct {
        logic [5:0]  hsel;
        logic [2:0]  dsel;
        logic        dselDef;
        logic        hrdy;
        logic        hresp;
        logic        ev;
        logic [31:0] ea;
        logic        ew;
        logic [1:0]  cnt;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic        hsel;
    logic        hready;
    logic [5:0]  slvEn;
    logic        errClr;

    logic [5:0]  hselSlv;
    logic [2:0]  dsel;
    logic        dselDef;
    logic        defHreadyout;
    logic        defHresp;
    logic        errValid;
    logic [31:0] errAddr;
    logic        errWrite;
    logic [1:0]  errCnt;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    ahb_addr_filter_err #(
        .NB_SLAVES (6),
        .ADDR_WIDTH(32),
        .CNT_WIDTH (2)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .haddr_i        (haddr),
        .htrans_i       (htrans),
        .hwrite_i       (hwrite),
        .hsel_i         (hsel),
        .hready_i       (hready),
        .slv_en_i       (slvEn),
        .hsel_slv_o     (hselSlv),
        .dsel_o         (dsel),
        .dsel_def_o     (dselDef),
        .def_hreadyout_o(defHreadyout),
        .def_hresp_o    (defHresp),
        .err_valid_o    (errValid),
        .err_addr_o     (errAddr),
        .err_write_o    (errWrite),
        .err_cnt_o      (errCnt),
        .err_clr_i      (errClr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mkExp(input logic [5:0] hs, input logic [2:0] ds, input logic dd,
                                   input logic rdy, input logic rsp, input logic ev,
                                   input logic [31:0] ea, input logic ew, input logic [1:0] cnt);
        exp_t e;
        e.hsel = hs; e.dsel = ds; e.dselDef = dd; e.hrdy = rdy; e.hresp = rsp;
        e.ev = ev; e.ea = ea; e.ew = ew; e.cnt = cnt;
        return e;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        cmp("hsel_slv",      32'(hselSlv),      32'(e.hsel));
        cmp("dsel",          32'(dsel),         32'(e.dsel));
        cmp("dsel_def",      32'(dselDef),      32'(e.dselDef));
        cmp("def_hreadyout", 32'(defHreadyout), 32'(e.hrdy));
        cmp("def_hresp",     32'(defHresp),     32'(e.hresp));
        cmp("err_valid",     32'(errValid),     32'(e.ev));
        cmp("err_addr",      errAddr,           e.ea);
        cmp("err_write",     32'(errWrite),     32'(e.ew));
        cmp("err_cnt",       32'(errCnt),       32'(e.cnt));
    endtask

    // Drive one cycle's inputs on the falling edge and queue what must be seen after the rising edge.
    task automatic applyStimulus(input logic r, input logic clr, input logic [1:0] tr,
                                 input logic [31:0] a, input logic wr, input logic hs,
                                 input logic hr, input logic [5:0] en, input exp_t e);
        @(negedge clk);
        rst = r; errClr = clr; htrans = tr; haddr = a; hwrite = wr;
        hsel = hs; hready = hr; slvEn = en;
        expQ.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (expQ.size() > 0) begin
            checkOutput(expQ.pop_front());
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1; errClr = 1'b0; htrans = HTRANS_IDLE; haddr = '0; hwrite = 1'b0;
        hsel = 1'b0; hready = 1'b1; slvEn = 6'h3F;

        // rst clr  trans          addr           wr hs hr en     hsel       ds dd rdy rsp ev ea            ew cnt
        applyStimulus(1, 0, HTRANS_IDLE,   32'h0000_0000, 0, 0, 1, 6'h3F, mkExp(6'b000000, 0, 1, 1, 0, 0, 32'h0,         0, 0));
        applyStimulus(0, 0, HTRANS_NONSEQ, 32'h2000_0010, 0, 1, 1, 6'h3F, mkExp(6'b000100, 2, 0, 1, 0, 0, 32'h0,         0, 0));
        applyStimulus(0, 0, HTRANS_IDLE,   32'h0000_0000, 0, 0, 1, 6'h3F, mkExp(6'b000000, 2, 1, 1, 0, 0, 32'h0,         0, 0));
        applyStimulus(0, 0, HTRANS_NONSEQ, 32'h7000_0000, 1, 1, 1, 6'h3F, mkExp(6'b000000, 0, 1, 0, 1, 1, 32'h7000_0000, 1, 1));
        applyStimulus(0, 0, HTRANS_IDLE,   32'h1000_0000, 0, 1, 0, 6'h3F, mkExp(6'b000010, 0, 1, 1, 1, 1, 32'h7000_0000, 1, 1));
        applyStimulus(0, 0, HTRANS_IDLE,   32'h1000_0000, 0, 1, 1, 6'h3F, mkExp(6'b000010, 1, 0, 1, 0, 1, 32'h7000_0000, 1, 1));
        // region 2 disabled at runtime
        applyStimulus(0, 0, HTRANS_NONSEQ, 32'h2000_0000, 0, 1, 1, 6'h3B, mkExp(6'b000000, 0, 1, 0, 1, 1, 32'h7000_0000, 1, 2));
        applyStimulus(0, 0, HTRANS_IDLE,   32'h2000_0000, 0, 1, 0, 6'h3B, mkExp(6'b000000, 0, 1, 1, 1, 1, 32'h7000_0000, 1, 2));
        applyStimulus(0, 0, HTRANS_IDLE,   32'h2000_0000, 0, 1, 1, 6'h3B, mkExp(6'b000000, 0, 1, 1, 0, 1, 32'h7000_0000, 1, 2));
        applyStimulus(0, 0, HTRANS_IDLE,   32'h2000_0000, 0, 1, 1, 6'h3B, mkExp(6'b000000, 0, 1, 1, 0, 1, 32'h7000_0000, 1, 2));
        // clear alone keeps the captured address
        applyStimulus(0, 1, HTRANS_IDLE,   32'h0000_0000, 0, 0, 1, 6'h3F, mkExp(6'b000000, 0, 1, 1, 0, 0, 32'h7000_0000, 1, 0));
        // back-to-back errors: ERR2 -> ERR1 directly
        applyStimulus(0, 0, HTRANS_NONSEQ, 32'h6000_0000, 0, 1, 1, 6'h3F, mkExp(6'b000000, 0, 1, 0, 1, 1, 32'h6000_0000, 0, 1));
        applyStimulus(0, 0, HTRANS_SEQ,    32'h6000_0004, 1, 1, 0, 6'h3F, mkExp(6'b000000, 0, 1, 1, 1, 1, 32'h6000_0000, 0, 1));
        applyStimulus(0, 0, HTRANS_SEQ,    32'h6000_0004, 1, 1, 1, 6'h3F, mkExp(6'b000000, 0, 1, 0, 1, 1, 32'h6000_0000, 0, 2));
        applyStimulus(0, 0, HTRANS_IDLE,   32'h0000_0000, 0, 1, 0, 6'h3F, mkExp(6'b000001, 0, 1, 1, 1, 1, 32'h6000_0000, 0, 2));
        applyStimulus(0, 0, HTRANS_IDLE,   32'h0000_0000, 0, 0, 1, 6'h3F, mkExp(6'b000000, 0, 1, 1, 0, 1, 32'h6000_0000, 0, 2));
        // saturation of the 2-bit counter
        applyStimulus(0, 0, HTRANS_NONSEQ, 32'hA000_0000, 0, 1, 1, 6'h3F, mkExp(6'b000000, 0, 1, 0, 1, 1, 32'h6000_0000, 0, 3));
        applyStimulus(0, 0, HTRANS_IDLE,   32'h0000_0000, 0, 0, 0, 6'h3F, mkExp(6'b000000, 0, 1, 1, 1, 1, 32'h6000_0000, 0, 3));
        applyStimulus(0, 0, HTRANS_NONSEQ, 32'hB000_0000, 0, 1, 1, 6'h3F, mkExp(6'b000000, 0, 1, 0, 1, 1, 32'h6000_0000, 0, 3));
        applyStimulus(0, 0, HTRANS_IDLE,   32'h0000_0000, 0, 0, 0, 6'h3F, mkExp(6'b000000, 0, 1, 1, 1, 1, 32'h6000_0000, 0, 3));
        applyStimulus(0, 0, HTRANS_IDLE,   32'h0000_0000, 0, 0, 1, 6'h3F, mkExp(6'b000000, 0, 1, 1, 0, 1, 32'h6000_0000, 0, 3));
        // clear coincident with a new error
        applyStimulus(0, 1, HTRANS_NONSEQ, 32'h9000_0000, 1, 1, 1, 6'h3F, mkExp(6'b000000, 0, 1, 0, 1, 1, 32'h9000_0000, 1, 1));
        applyStimulus(0, 0, HTRANS_IDLE,   32'h0000_0000, 0, 0, 0, 6'h3F, mkExp(6'b000000, 0, 1, 1, 1, 1, 32'h9000_0000, 1, 1));
        applyStimulus(0, 0, HTRANS_IDLE,   32'h0000_0000, 0, 0, 1, 6'h3F, mkExp(6'b000000, 0, 1, 1, 0, 1, 32'h9000_0000, 1, 1));
        // reset while in ERR1
        applyStimulus(0, 0, HTRANS_NONSEQ, 32'h8000_0000, 0, 1, 1, 6'h3F, mkExp(6'b000000, 0, 1, 0, 1, 1, 32'h9000_0000, 1, 2));
        applyStimulus(1, 0, HTRANS_IDLE,   32'h0000_0000, 0, 0, 0, 6'h3F, mkExp(6'b000000, 0, 1, 1, 0, 0, 32'h0,         0, 0));
        // region boundaries, disabled low region, unselected and BUSY accesses
        applyStimulus(0, 0, HTRANS_NONSEQ, 32'h5FFF_FFFF, 1, 1, 1, 6'h3F, mkExp(6'b100000, 5, 0, 1, 0, 0, 32'h0,         0, 0));
        applyStimulus(0, 0, HTRANS_SEQ,    32'h1000_0000, 0, 1, 1, 6'h3E, mkExp(6'b000010, 1, 0, 1, 0, 0, 32'h0,         0, 0));
        applyStimulus(0, 0, HTRANS_NONSEQ, 32'h7000_0000, 0, 0, 1, 6'h3F, mkExp(6'b000000, 1, 1, 1, 0, 0, 32'h0,         0, 0));
        applyStimulus(0, 0, HTRANS_BUSY,   32'h7000_0000, 0, 1, 1, 6'h3F, mkExp(6'b000000, 0, 1, 1, 0, 0, 32'h0,         0, 0));
        applyStimulus(0, 0, HTRANS_NONSEQ, 32'h3000_0000, 0, 1, 0, 6'h3F, mkExp(6'b001000, 0, 1, 1, 0, 0, 32'h0,         0, 0));

        for (int k = 0; k < 10 && expQ.size() != 0; k++) @(negedge clk);
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain pending=%0d required=0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
